// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared state type, default limits and counter sizing for the button event decoder
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HELD = 3'd2,
    GAP       = 3'd3,
    PRESS2    = 3'd4
  } button_state_t;

  // 1 s and 300 ms at a 25 MHz system clock
  localparam int c_DEFAULT_LONG_LIMIT = 25000000;
  localparam int c_DEFAULT_DOUBLE_GAP = 7500000;

  // Width that can hold the larger of the two limits without wrapping
  function automatic int count_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_event_decoder_event_timer.sv
// rtl/button_event_decoder_event_timer.sv - shared duration counter with last-count flag
module event_timer #(
  parameter int c_WIDTH = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Clear,
  input  logic               i_Load_One,
  input  logic               i_Enable,
  input  logic [c_WIDTH-1:0] i_Limit,
  output logic               o_Last
);

  logic [c_WIDTH-1:0] r_Count;

  // Clear wins over load; increments saturate so the count never wraps
  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      r_Count <= '0;
    end else if (i_Load_One) begin
      r_Count <= c_WIDTH'(1);
    end else if (i_Enable && (r_Count != {c_WIDTH{1'b1}})) begin
      r_Count <= r_Count + c_WIDTH'(1);
    end
  end

  // Flags that the sample being taken now is the limit-th one of the run
  always_comb begin
    o_Last = (r_Count == (i_Limit - c_WIDTH'(1)));
  end

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - decodes a debounced level into short/long/double press pulses (optional DOUBLE_PRESS_EN)
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int c_LONG_LIMIT = c_DEFAULT_LONG_LIMIT,
  parameter int c_DOUBLE_GAP = c_DEFAULT_DOUBLE_GAP
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Short_Press,
  output logic o_Long_Press,
  output logic o_Double_Press,
  output logic o_Held
);

  localparam int c_CNT_W = count_width(c_LONG_LIMIT, c_DOUBLE_GAP);
  localparam logic [c_CNT_W-1:0] c_LONG_LIM_W = c_CNT_W'(c_LONG_LIMIT);
`ifdef DOUBLE_PRESS_EN
  localparam logic [c_CNT_W-1:0] c_GAP_LIM_W = c_CNT_W'(c_DOUBLE_GAP);
`endif

  button_state_t r_State, w_Next_State;
  logic w_Clear, w_Load_One, w_Enable, w_Last;
  logic [c_CNT_W-1:0] w_Limit;
  logic w_Short, w_Long;
`ifdef DOUBLE_PRESS_EN
  logic w_Double;
`endif

  event_timer #(
    .c_WIDTH(c_CNT_W)
  ) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Clear    (w_Clear),
    .i_Load_One (w_Load_One),
    .i_Enable   (w_Enable),
    .i_Limit    (w_Limit),
    .o_Last     (w_Last)
  );

  // State and registered event outputs
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State       <= IDLE;
      o_Short_Press <= 1'b0;
      o_Long_Press  <= 1'b0;
      o_Held        <= 1'b0;
    end else begin
      r_State       <= w_Next_State;
      o_Short_Press <= w_Short;
      o_Long_Press  <= w_Long;
      o_Held        <= (w_Next_State == LONG_HELD);
    end
  end

`ifdef DOUBLE_PRESS_EN
  // Registered double-press pulse exists only when the gap logic is built
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Double_Press <= 1'b0;
    end else begin
      o_Double_Press <= w_Double;
    end
  end
`else
  assign o_Double_Press = 1'b0;
`endif

  // Next state, counter control and next-cycle event pulses
  always_comb begin
    w_Next_State = r_State;
    w_Clear      = 1'b0;
    w_Load_One   = 1'b0;
    w_Enable     = 1'b0;
    w_Limit      = c_LONG_LIM_W;
    w_Short      = 1'b0;
    w_Long       = 1'b0;
`ifdef DOUBLE_PRESS_EN
    w_Double     = 1'b0;
`endif
    case (r_State)
      IDLE: begin
        if (i_Switch) begin
          w_Next_State = PRESS1;
          w_Load_One   = 1'b1;
        end else begin
          w_Clear = 1'b1;
        end
      end
      PRESS1: begin
        if (i_Switch) begin
          if (w_Last) begin
            w_Long       = 1'b1;
            w_Next_State = LONG_HELD;
            w_Clear      = 1'b1;
          end else begin
            w_Enable = 1'b1;
          end
        end else begin
`ifdef DOUBLE_PRESS_EN
          w_Next_State = GAP;
          w_Load_One   = 1'b1;
`else
          w_Short      = 1'b1;
          w_Next_State = IDLE;
          w_Clear      = 1'b1;
`endif
        end
      end
      LONG_HELD: begin
        w_Clear = 1'b1;
        if (!i_Switch) begin
          w_Next_State = IDLE;
        end
      end
`ifdef DOUBLE_PRESS_EN
      GAP: begin
        w_Limit = c_GAP_LIM_W;
        if (!i_Switch) begin
          if (w_Last) begin
            w_Short      = 1'b1;
            w_Next_State = IDLE;
            w_Clear      = 1'b1;
          end else begin
            w_Enable = 1'b1;
          end
        end else begin
          w_Next_State = PRESS2;
          w_Clear      = 1'b1;
        end
      end
      PRESS2: begin
        w_Clear = 1'b1;
        if (!i_Switch) begin
          w_Double     = 1'b1;
          w_Next_State = IDLE;
        end
      end
`endif
      default: begin
        w_Next_State = IDLE;
        w_Clear      = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed and randomised checks of button_event_decoder
module tb_button_event_decoder;

  logic i_Clk = 1'b0;
  logic i_Rst;
  logic i_Switch;
  logic o_Short_Press, o_Long_Press, o_Double_Press, o_Held;

  int n_total = 0;
  int n_bad   = 0;
  int cyc, n_s, n_l, n_d, first_s, last_s, at_l, at_d, multi;

  button_event_decoder #(
    .c_LONG_LIMIT(10),
    .c_DOUBLE_GAP(5)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst          (i_Rst),
    .i_Switch       (i_Switch),
    .o_Short_Press  (o_Short_Press),
    .o_Long_Press   (o_Long_Press),
    .o_Double_Press (o_Double_Press),
    .o_Held         (o_Held)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    cyc = 0; n_s = 0; n_l = 0; n_d = 0;
    first_s = -1; last_s = -1; at_l = -1; at_d = -1; multi = 0;
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      i_Switch = v;
      @(posedge i_Clk);
      #1;
      cyc++;
      if (o_Short_Press) begin
        n_s++;
        if (first_s < 0) first_s = cyc;
        last_s = cyc;
      end
      if (o_Long_Press) begin
        n_l++;
        at_l = cyc;
      end
      if (o_Double_Press) begin
        n_d++;
        at_d = cyc;
      end
      if ((int'(o_Short_Press) + int'(o_Long_Press) + int'(o_Double_Press)) > 1) multi++;
    end
  endtask

  int h, g, h2, kind, exp_code;

  initial begin
    i_Rst = 1'b1;
    i_Switch = 1'b0;
    clear_counts();

    // reset
    drive(1'b0, 3);
    check("reset_outputs", {o_Short_Press, o_Long_Press, o_Double_Press, o_Held}, 4'b0000);
    i_Rst = 1'b0;
    clear_counts();
    drive(1'b0, 20);
    check("idle_no_pulse", n_s + n_l + n_d, 0);
    check("idle_held", o_Held, 0);

    // short press: 3 high then low
    clear_counts();
    drive(1'b1, 3);
    drive(1'b0, 10);
    check("short_count", n_s, 1);
`ifdef DOUBLE_PRESS_EN
    check("short_time", first_s, 8);
`else
    check("short_time", first_s, 4);
`endif
    check("short_no_other", n_l + n_d, 0);

    // long press: exactly 10 highs
    clear_counts();
    drive(1'b1, 9);
    check("long_pre_held", o_Held, 0);
    check("long_pre_count", n_l, 0);
    drive(1'b1, 1);
    check("long_pulse_now", o_Long_Press, 1);
    check("long_held_rise", o_Held, 1);
    drive(1'b1, 5);
    check("long_held_stay", o_Held, 1);
    check("long_once", n_l, 1);
    check("long_time", at_l, 10);
    drive(1'b0, 1);
    check("long_held_fall", o_Held, 0);
    drive(1'b0, 10);
    check("long_no_short", n_s + n_d, 0);

    // 9 highs: short only
    clear_counts();
    drive(1'b1, 9);
    drive(1'b0, 10);
    check("nine_no_long", n_l, 0);
    check("nine_short", n_s, 1);
`ifdef DOUBLE_PRESS_EN
    check("nine_time", first_s, 14);
`else
    check("nine_time", first_s, 10);
`endif

    // 3 high, 4 low, 2 high, release
    clear_counts();
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 2);
    drive(1'b0, 1);
`ifdef DOUBLE_PRESS_EN
    check("dbl_pulse_now", o_Double_Press, 1);
    drive(1'b0, 10);
    check("dbl_count", n_d, 1);
    check("dbl_no_short", n_s, 0);
    check("dbl_time", at_d, 10);
`else
    check("dbl_off_short_now", o_Short_Press, 1);
    drive(1'b0, 10);
    check("dbl_off_shorts", n_s, 2);
    check("dbl_off_first", first_s, 4);
    check("dbl_off_none", n_d, 0);
`endif

    // 3 high, 5 low, 2 high, release: two separate shorts
    clear_counts();
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 2);
    drive(1'b0, 10);
    check("gap5_shorts", n_s, 2);
    check("gap5_no_dbl", n_d, 0);
`ifdef DOUBLE_PRESS_EN
    check("gap5_first", first_s, 8);
    check("gap5_second", last_s, 15);
`else
    check("gap5_first", first_s, 4);
    check("gap5_second", last_s, 11);
`endif

    // reset mid-press with switch held
    clear_counts();
    drive(1'b1, 8);
    i_Rst = 1'b1;
    drive(1'b1, 2);
    i_Rst = 1'b0;
    check("rst_mid_no_pulse", n_s + n_l + n_d, 0);
    check("rst_mid_held", o_Held, 0);
    clear_counts();
    drive(1'b1, 9);
    check("rst_post_no_long", n_l, 0);
    drive(1'b1, 1);
    check("rst_post_long", n_l, 1);
    check("rst_post_time", at_l, 10);
    drive(1'b0, 10);
    check("rst_post_held", o_Held, 0);

    // random sequences against a reference model
    for (int s = 0; s < 30; s++) begin
      clear_counts();
      kind = $urandom_range(0, 1);
      if (kind == 0) begin
        h = $urandom_range(1, 14);
        drive(1'b1, h);
        drive(1'b0, 8);
        exp_code = (h >= 10) ? 10 : 100;
      end else begin
        h  = $urandom_range(1, 9);
        g  = $urandom_range(1, 4);
        h2 = $urandom_range(1, 14);
        drive(1'b1, h);
        drive(1'b0, g);
        drive(1'b1, h2);
        drive(1'b0, 8);
`ifdef DOUBLE_PRESS_EN
        exp_code = 1;
`else
        exp_code = (h2 >= 10) ? 110 : 200;
`endif
      end
      check($sformatf("rand_%0d_events", s), n_s * 100 + n_l * 10 + n_d, exp_code);
      check($sformatf("rand_%0d_overlap", s), multi, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the clean, debounced level from a switch debouncer and decodes it into discrete user events: short press, long press and double press, each a single-cycle pulse. It sits between the debouncer output and application logic, such as the 7-segment counter and mode control. Press/release durations are measured in clock cycles with one shared duration counter and a small FSM.

## Interface
- c_LONG_LIMIT, 25000000: consecutive high samples that make a long press (1 s at 25 MHz); must be ≥ 2
- c_DOUBLE_GAP, 7500000: maximum consecutive low samples between clicks of a double press (300 ms at 25 MHz); must be ≥ 2
- i_Clk  in  1  system clock; all logic on rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_Switch  in  1  debounced level, 1 = pressed; already synchronous to i_Clk
- o_Short_Press  out  1  one-cycle pulse: single short click recognised
- o_Long_Press  out  1  one-cycle pulse: press held c_LONG_LIMIT samples
- o_Double_Press  out  1  one-cycle pulse: two clicks within gap
- o_Held  out  1  level; high while a recognised long press is still held

## Operation
- All outputs are registered. On reset, the state is IDLE, the counter is 0 and all outputs are 0.
- FSM states and transitions:
  - IDLE: sampling i_Switch = 1 moves to PRESS1 with counter = 1.
  - PRESS1, while held: the counter increments. When the counter reaches c_LONG_LIMIT, the block pulses o_Long_Press and moves to LONG_HELD.
  - PRESS1, on a low sample: moves to GAP with counter = 1. See Configuration for the case where DOUBLE_PRESS_EN is not defined.
  - LONG_HELD: o_Held = 1. A low sample moves to IDLE and clears o_Held. Release emits no pulse.
  - GAP, while low: the counter increments. When the counter reaches c_DOUBLE_GAP, the block pulses o_Short_Press and moves to IDLE.
  - GAP, on a high sample before the limit: moves to PRESS2.
  - PRESS2: has no duration check. A low sample pulses o_Double_Press and moves to IDLE.
- At most one event pulse is asserted in any cycle. Every press sequence yields exactly one event.
- Counter width is $clog2(max(c_LONG_LIMIT, c_DOUBLE_GAP)+1). The counter is cleared or loaded on every state entry and never wraps.
- Reset mid-operation abandons the sequence with no pulse. If i_Switch is high when reset deasserts, the first high sample after reset starts a new press.
- Unused states decode to IDLE.

## Timing
- Sample k means i_Switch as seen at clock edge k.
- Long press: when sample k is the c_LONG_LIMIT-th consecutive high sample, o_Long_Press is high for the cycle after edge k, and o_Held rises on the same edge.
- A press of exactly c_LONG_LIMIT−1 high samples is short.
- Short press (DOUBLE_PRESS_EN defined): o_Short_Press goes high after the c_DOUBLE_GAP-th consecutive low sample.
- A gap of c_DOUBLE_GAP−1 low samples still counts as a double press.
- Double press: o_Double_Press goes high on the edge after the first low sample in PRESS2.
- o_Held falls on the edge after the first low sample in LONG_HELD.
- Latency from the qualifying sample to a pulse is 1 cycle in all cases.

## Configuration
- DOUBLE_PRESS_EN defined: full behaviour as above; GAP and PRESS2 states exist.
- DOUBLE_PRESS_EN undefined:
  - GAP and PRESS2 are not compiled.
  - A low sample in PRESS1 pulses o_Short_Press and moves to IDLE, so the pulse comes 1 cycle after the first low sample.
  - o_Double_Press is tied to 0.
  - c_DOUBLE_GAP is ignored.

## Structure
- Package button_event_pkg holds:
  - typedef for the state enum (IDLE, PRESS1, LONG_HELD, GAP, PRESS2)
  - default limit constants
  - counter-width function
- One sub-module, event_timer, is the natural split: a duration counter with inputs clear/load-1, enable and limit, and a terminal-count flag output. The FSM instantiates it once.

## Test plan
All scenarios use c_LONG_LIMIT = 10 and c_DOUBLE_GAP = 5.
- Reset with i_Switch = 0 for 3 cycles, then release: all outputs stay 0 and no pulse appears within 20 cycles.
- 3 high samples, then low held, DOUBLE_PRESS_EN defined: o_Short_Press pulses exactly once, 1 cycle after the 5th low sample. With the macro undefined, it pulses 1 cycle after the 1st low sample.
- Hold 10 samples: o_Long_Press pulses once, after the 10th high sample, and o_Held stays 1 until 1 cycle after release with no short pulse. Repeat with 9 samples: short press only.
- 3 high, 4 low, 2 high, release: one o_Double_Press after the first low sample, and no o_Short_Press. With 5 low instead: o_Short_Press, then a separate short press for the second click.
- Reset pulsed at PRESS1 count 8 with i_Switch kept high: no pulses. After reset deasserts, o_Long_Press appears after the 10th post-reset high sample.
- Random press/release durations against a reference model: exactly one event per sequence, never two pulses in one cycle.
